// File: rtl/bf_io_pkg.sv
// Shared definitions for the brainfuck core's character I/O peripherals.
// Holds the UART framer state encoding and the frame constants.
package bf_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS           = 8;
    localparam int STOP_BITS           = 1;
    localparam int DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/bf_sync_fifo.sv
// Byte-wide synchronous FIFO with a sticky overflow flag for dropped writes.
// Read data is taken combinationally from the head entry.
module bf_sync_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic                       overflow_q, overflow_d;
    logic                       do_push;
    logic                       do_pop;

    assign full     = (count_q == COUNT_FULL);
    assign empty    = (count_q == '0);
    assign dout     = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    // Fullness is judged on the pre-edge count, so a pop never frees a slot
    // for a push in the same cycle.
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (push && full);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/bf_uart_tx.sv
// UART 8N1 transmitter for the brainfuck core's '.' output strobe.
// Bytes are queued in a small FIFO and framed back-to-back, LSB first.
module bf_uart_tx
    import bf_io_pkg::*;
#(
    parameter int CLK_PER_BIT     = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sendingChar,
    input  logic [7:0] sendedChar,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic              baud_end;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    bf_sync_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (sendingChar),
        .pop     (pop),
        .din     (sendedChar),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .overflow(overflow)
    );

    assign tx_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Directed bench for bf_uart_tx with CLK_PER_BIT=4, so each UART bit is one
// hex nibble (0 or F) of the expected line waveforms below.
module tb_bf_uart_tx;

    localparam int CPB = 4;
    localparam int L2  = 2;
    localparam int H   = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sendingChar = 1'b0;
    logic [7:0] sendedChar = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       overflow;

    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    logic hist [H];

    always #5 clk = ~clk;

    bf_uart_tx #(
        .CLK_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2(L2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sendingChar(sendingChar),
        .sendedChar (sendedChar),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow)
    );

    // Line history: hist[k] is tx as seen just after posedge number k.
    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        #1 hist[edge_cnt % H] = tx;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] grab(input int start, input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[126:0], hist[(start + i) % H]};
        end
        return v;
    endfunction

    initial begin
        int n;
        int m;
        logic [39:0] exp3 [5];
        logic [7:0] tape [16];
        int p;
        int pc;
        int depth;
        int steps;
        int e_out;
        string prog;

        // Reset state
        tick(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        tick(2);

        // Single byte 0x41
        sendingChar = 1'b1;
        sendedChar  = 8'h41;
        tick();
        n = edge_cnt;
        sendingChar = 1'b0;
        chk("t1_tx_after_write", tx, 1'b1);
        chk("t1_busy_after_write", busy, 1'b1);
        tick();
        chk("t1_start_bit", tx, 1'b0);
        tick(40);
        chk("t1_frame", grab(n + 1, 40), 40'h0F00000F0F);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_tx_idle", tx, 1'b1);
        tick(3);

        // Back-to-back 0x00, 0xFF, 0x55
        sendingChar = 1'b1;
        sendedChar  = 8'h00;
        tick();
        n = edge_cnt;
        sendedChar = 8'hFF;
        tick();
        sendedChar = 8'h55;
        tick();
        sendingChar = 1'b0;
        tick(119);
        chk("t2_frames", grab(n + 1, 120), {40'h000000000F, 40'h0FFFFFFFFF, 40'h0F0F0F0F0F});
        chk("t2_idle_after", tx, 1'b1);
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_overflow", overflow, 1'b0);
        tick(3);

        // Six writes into depth-4 FIFO: sixth is dropped
        exp3[0] = 40'h0F000F000F;
        exp3[1] = 40'h00F000F00F;
        exp3[2] = 40'h0FF00FF00F;
        exp3[3] = 40'h000F000F0F;
        exp3[4] = 40'h0F0F0F0F0F;
        sendingChar = 1'b1;
        sendedChar  = 8'h11;
        tick();
        n = edge_cnt;
        sendedChar = 8'h22;
        tick();
        sendedChar = 8'h33;
        tick();
        sendedChar = 8'h44;
        tick();
        sendedChar = 8'h55;
        tick();
        chk("t3_full_ready", tx_ready, 1'b0);
        chk("t3_no_ovf_yet", overflow, 1'b0);
        sendedChar = 8'h66;
        tick();
        sendingChar = 1'b0;
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_still_full", tx_ready, 1'b0);
        tick(196);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_frame%0d", k), grab(n + 1 + 40 * k, 40), exp3[k]);
        end
        chk("t3_busy_end", busy, 1'b0);
        chk("t3_overflow_sticky", overflow, 1'b1);

        // Push on the cycle the FSM pops with the FIFO full
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(2);
        sendingChar = 1'b1;
        sendedChar  = 8'hC0;
        tick();
        n = edge_cnt;
        for (int k = 1; k < 5; k++) begin
            sendedChar = 8'hC0 + 8'(k);
            tick();
        end
        sendingChar = 1'b0;
        tick(36);
        chk("t4_full_before_pop", tx_ready, 1'b0);
        chk("t4_no_ovf_before", overflow, 1'b0);
        sendingChar = 1'b1;
        sendedChar  = 8'hEE;
        tick();
        sendingChar = 1'b0;
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_ready_count3", tx_ready, 1'b1);
        chk("t4_next_start", tx, 1'b0);
        tick(160);
        chk("t4_busy_after_4_more", busy, 1'b0);
        tick(3);

        // Reset during data bit 3 of 0xA5
        sendingChar = 1'b1;
        sendedChar  = 8'hA5;
        tick();
        n = edge_cnt;
        sendingChar = 1'b0;
        tick(17);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_prefix", grab(n + 1, 17), 17'b0000_1111_0000_1111_0);
        chk("t5_rst_tx", tx, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", tx_ready, 1'b1);
        chk("t5_rst_overflow", overflow, 1'b0);
        tick();
        sendingChar = 1'b1;
        sendedChar  = 8'h3C;
        tick();
        m = edge_cnt;
        sendingChar = 1'b0;
        tick(41);
        chk("t5_clean_frame", grab(m + 1, 40), 40'h000FFFF00F);
        chk("t5_busy_end", busy, 1'b0);
        tick(3);

        // Core integration: run the program and emit each '.' as a write
        prog = "++++++++[>++++++++<-]>+.";
        for (int k = 0; k < 16; k++) tape[k] = 8'h00;
        p = 0;
        pc = 0;
        steps = 0;
        e_out = 0;
        while (pc < prog.len() && steps < 10000) begin
            steps++;
            if (prog[pc] == "+") tape[p] = tape[p] + 8'd1;
            else if (prog[pc] == "-") tape[p] = tape[p] - 8'd1;
            else if (prog[pc] == ">") p = p + 1;
            else if (prog[pc] == "<") p = p - 1;
            else if (prog[pc] == "[" && tape[p] == 8'h00) begin
                depth = 1;
                while (depth > 0) begin
                    pc++;
                    if (prog[pc] == "[") depth++;
                    else if (prog[pc] == "]") depth--;
                end
            end else if (prog[pc] == "]" && tape[p] != 8'h00) begin
                depth = 1;
                while (depth > 0) begin
                    pc--;
                    if (prog[pc] == "]") depth++;
                    else if (prog[pc] == "[") depth--;
                end
            end else if (prog[pc] == ".") begin
                chk("core_tx_ready", tx_ready, 1'b1);
                sendingChar = 1'b1;
                sendedChar  = tape[p];
                tick();
                e_out = edge_cnt;
                sendingChar = 1'b0;
                tick(24);
            end
            pc++;
        end
        tick(60);
        chk("core_frame", grab(e_out + 1, 40), 40'h0F00000F0F);
        chk("core_no_second_frame", grab(e_out + 41, 40), 40'hFFFFFFFFFF);
        chk("core_busy_end", busy, 1'b0);
        chk("core_overflow", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bf_uart_tx.md
Name: bf_uart_tx

Overview:
- Output-side peripheral for the brainfuck core's `.` interface.
- Accepts the core's one-cycle `sendingChar` / `sendedChar` strobe and drives `tx_ready` back to the core.
- Buffers characters in a small FIFO and serialises them as UART 8N1, LSB first, on a single `tx` line.
- Sits between the core's parallel char interface and the board's UART TX pin.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- FIFO_DEPTH_LOG2, 2, log2 of the FIFO depth (default depth = 4 bytes).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- sendingChar  in  1  byte-write strobe from the core; each cycle it is high is one write.
- sendedChar  in  8  byte to transmit; valid when sendingChar=1.
- tx_ready  out  1  1 when the FIFO can accept a byte.
- tx  out  1  UART serial output; idle high.
- busy  out  1  1 while a frame is on the line or the FIFO is non-empty.
- overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=1 at a posedge) takes priority over everything and applies mid-frame:
  - tx=1, tx_ready=1, busy=0, overflow=0.
  - FIFO count=0, read/write pointers=0, FSM=IDLE, baud and bit counters=0.
  - Any frame in progress is truncated; tx returns high on the cycle after the reset edge.
- Count and flags:
  - count is a (FIFO_DEPTH_LOG2+1)-bit register.
  - full = (count == 2^FIFO_DEPTH_LOG2); empty = (count == 0).
  - tx_ready = !full, decoded from the registered count (no same-cycle combinational path from sendingChar).
- Push:
  - A write is accepted iff sendingChar=1 and !full, evaluated on pre-edge state.
  - A write while full is dropped and sets overflow; overflow stays set until reset.
  - A simultaneous pop does not make room for a push in the same cycle, even when full.
- Push and pop in the same cycle: count is unchanged and both pointers advance; pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head byte into an 8-bit shift register, drive tx=0, clear the baud counter, go to START. Otherwise tx=1.
  - START: tx=0 for CLK_PER_BIT cycles, then tx=shift[0], bit counter=0, go to DATA.
  - DATA: each bit is held for CLK_PER_BIT cycles; shift right on each bit boundary. After bit 7 completes, tx=1 and go to STOP.
  - STOP: tx=1 for CLK_PER_BIT cycles. At the end:
    - if !empty, pop and enter START directly (no idle cycle between frames);
    - otherwise go to IDLE.
- Baud counter counts 0..CLK_PER_BIT-1 and wraps, giving exactly 10*CLK_PER_BIT cycles per frame.
- Latency: a write accepted at edge N into an empty FIFO with FSM=IDLE:
  - the FIFO holds the byte after edge N;
  - the pop happens at edge N+1;
  - tx=0 from edge N+1 onward.
- busy = (FSM != IDLE) || !empty, registered-equivalent.
- Core timing: the core waits 24 cycles after each `.` and re-samples tx_ready before the next write. No back-pressure beyond tx_ready is required; the drop/overflow rule covers protocol misuse.

Decomposition:
- Shared include package bf_io_pkg:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3);
  - UART frame constants (DATA_BITS=8, STOP_BITS=1);
  - the default CLK_PER_BIT.
  - The future bf_uart_rx block (feeding receivingChar/receivedChar) reuses this package.
- Sub-module bf_sync_fifo (parameter FIFO_DEPTH_LOG2, width 8):
  - ports push, pop, din, dout, full, empty, overflow;
  - read data is combinational from the head entry.
- The top level holds the FSM and the baud and bit counters.

Test Plan:
- Single byte, CLK_PER_BIT=4: pulse sendingChar=1, sendedChar=8'h41 at edge 10. Required:
  - tx=0 over edges 11..14;
  - data bits 1,0,0,0,0,0,1,0 for 4 cycles each;
  - tx=1 stop bit over edges 47..50;
  - busy=0 after edge 51.
- Back-to-back, CLK_PER_BIT=4: write 8'h00, 8'hFF, 8'h55 on three consecutive cycles. Required:
  - three frames with no idle gap: the stop bit of frame n is followed immediately by the start bit of frame n+1;
  - total 120 cycles of activity;
  - overflow=0.
- Full/overflow, depth 4, CLK_PER_BIT=4: write 6 bytes on consecutive cycles starting with FSM idle. Required:
  - the first byte pops, so 5 are accepted;
  - tx_ready=0 once count=4;
  - the 6th byte is dropped and overflow=1;
  - the transmitted sequence omits the 6th byte.
- Simultaneous push/pop while full: hold sendingChar=1 on the cycle the FSM pops with count=4. Required: the push is rejected, overflow=1, count ends at 3.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hA5. Required:
  - tx=1, busy=0, tx_ready=1, overflow=0 after the reset edge;
  - a subsequent write of 8'h3C produces a clean full frame.
- Core integration: drive a brainfuck core running "++++++++[>++++++++<-]>+." with CLK_PER_BIT=4. Required: exactly one frame carrying 8'h41 appears on tx, and tx_ready is never observed low by the core.
